spi_flash_arbiter: RTL and testbench
====================================

# spi_flash_arbiter

Shares the single board SPI boot/config flash between the DSP SPI master (chip-select 0) and the CPU SPI0 master. Each master raises a level request and waits for its grant (software polls the grant through a GPIO) before asserting chip-select. The arbiter grants ownership round-robin, never revokes ownership mid-transaction except on watchdog timeout, and inserts a guard gap between owners. It sits in the CPLD top level between the two 1V8 SPI banks and the 3V3 flash pins, clocked by the UFM oscillator (3.3–5.5 MHz).

## Interface
- GUARD_CYCLES, 4, idle sysclk cycles with no owner between successive grants (≥1)
- TIMEOUT_CYCLES, 4000000, maximum sysclk cycles one owner may hold the flash (~0.8 s at 5 MHz)
- TIMEOUT_WIDTH, 22, width of the hold counter; must hold TIMEOUT_CYCLES-1
- sysclk  in  1  arbiter clock (UFM oscillator); the only clock
- reset_INV  in  1  asynchronous, active-low reset
- enable  in  1  arbitration enable (DSP bank enable); low forces idle
- dsp_req, cpu_req  in  1 each  level request from each master, asynchronous
- dsp_grant, cpu_grant  out  1 each  registered grant, one-hot or zero
- dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV  in  1 each  DSP master SPI
- dsp_spi_miso  out  1  flash MISO to DSP
- cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV  in  1 each  CPU master SPI
- cpu_spi_miso  out  1  flash MISO to CPU
- flash_clk, flash_mosi, flash_cs_INV  out  1 each  flash pins
- flash_miso  in  1  flash MISO
- timeout  out  1  sticky: an owner was revoked by the watchdog
- timeout_clr  in  1  synchronous clear of timeout (one sysclk high)

## Operation
- dsp_req, cpu_req, dsp_spi_cs_INV and cpu_spi_cs_INV each pass through a 2-flop synchronizer (reset to 0, 0, 1, 1); the FSM sees only synchronized copies.
- SPI data path is combinational, selected by the grant registers, so it works at any SPI rate. Owner X: flash_clk/mosi/cs_INV = X's clk/mosi/cs_INV; X_spi_miso = flash_miso. Non-owner: X_spi_miso = 0. No owner: flash_cs_INV=1, flash_clk=0, flash_mosi=0.
- FSM states IDLE, OWN_DSP, OWN_CPU, DRAIN, GUARD; last_owner register (reset = CPU, so DSP wins the first tie).
- IDLE: both requests → grant the one that is not last_owner; one request → grant it; none → stay. Grant flop sets on the transition edge; hold counter clears; last_owner updates.
- OWN_x: req_x low → DRAIN (grant held). Hold counter reaches TIMEOUT_CYCLES-1 → grant drops, timeout set, → GUARD.
- DRAIN: grant held until synchronized cs_x_INV is 1, then grant drops → GUARD. Hold counter keeps running; timeout also applies here with the same action.
- GUARD: no grant; count GUARD_CYCLES; then → IDLE.
- Requests are sampled only in IDLE; a request that drops before being granted is forgotten.
- enable low (synchronous): next edge → IDLE, grants 0, guard and hold counters cleared; timeout retained. Enable high again resumes from IDLE.
- timeout_clr has priority over a simultaneous set only if no revocation occurs that cycle; set wins.
- Reset: state IDLE, grants 0, timeout 0, counters 0, so flash_cs_INV=1, flash_clk=0, flash_mosi=0, both MISO outputs 0.

## Timing
- Request to grant: req high before edge 0 → synchronized at edge 2 → grant high after edge 3 (3 cycles) if the FSM is in IDLE.
- Release: req low → synchronized 2 edges later → DRAIN on edge 3; if cs_INV is already high, grant drops at edge 4 after the cs sync.
- Owner handoff: the new grant appears no earlier than GUARD_CYCLES+1 edges after the old grant drops.
- Timeout: grant drops on the edge where the hold count equals TIMEOUT_CYCLES-1 (the TIMEOUT_CYCLES-th owned cycle); flash_cs_INV goes 1 combinationally.
- Grants are never both 1; a grant never changes while the owner's synchronized cs_INV is 0, except on timeout or enable low.

## Test plan
- Reset: hold reset_INV low with random inputs → flash_cs_INV=1, flash_clk=0, both grants 0, timeout 0; release reset → outputs remain idle.
- Single DSP: dsp_req=1 → dsp_grant=1 after 3 edges; DSP transfers 0x9F and the flash returns 0xEF4018 on dsp_spi_miso; cpu_spi_miso stays 0; drop req with cs high → grant 0 at +4 edges.
- Tie and round-robin: both requests rise together → DSP granted; DSP releases → cpu_grant rises exactly GUARD_CYCLES+1 edges after dsp_grant falls; repeat → DSP wins next.
- Drain: CPU drops req while cpu_spi_cs_INV=0 for 50 cycles → cpu_grant holds until 2 edges after cs rises; dsp_grant stays 0 throughout.
- Watchdog (TIMEOUT_CYCLES=100): DSP holds req and cs low → grant drops on the 100th owned cycle, flash_cs_INV=1, timeout=1; pulse timeout_clr → timeout=0.
- Enable drop mid-transfer: CPU owns and cs is low, enable→0 → next edge grants 0, flash_cs_INV=1; enable→1 with cpu_req still high → re-granted 1 edge later (inputs already synchronized).

Source files
------------

// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash between the DSP and CPU SPI masters,
// with synchronized requests/chip-selects, a guard gap between owners and a hold watchdog.
module spi_flash_arbiter #(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int unsigned TIMEOUT_WIDTH  = 22
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic enable,
  input  logic dsp_req,
  input  logic cpu_req,
  output logic dsp_grant,
  output logic cpu_grant,
  input  logic dsp_spi_clk,
  input  logic dsp_spi_mosi,
  input  logic dsp_spi_cs_INV,
  output logic dsp_spi_miso,
  input  logic cpu_spi_clk,
  input  logic cpu_spi_mosi,
  input  logic cpu_spi_cs_INV,
  output logic cpu_spi_miso,
  output logic flash_clk,
  output logic flash_mosi,
  output logic flash_cs_INV,
  input  logic flash_miso,
  output logic timeout,
  input  logic timeout_clr
);

  localparam int unsigned GUARD_WIDTH = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_WIDTH-1:0]   GUARD_LAST = GUARD_WIDTH'(GUARD_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] HOLD_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OWN_DSP = 3'd1;
  localparam logic [2:0] S_OWN_CPU = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_GUARD   = 3'd4;

  logic [1:0] r_dsp_req_sync;
  logic [1:0] r_cpu_req_sync;
  logic [1:0] r_dsp_cs_sync;
  logic [1:0] r_cpu_cs_sync;

  logic [2:0]               r_state;
  logic                     r_dsp_grant;
  logic                     r_cpu_grant;
  logic                     r_last_cpu;
  logic [TIMEOUT_WIDTH-1:0] r_hold;
  logic [GUARD_WIDTH-1:0]   r_guard;
  logic                     r_timeout;

  logic [2:0]               w_state_nxt;
  logic                     w_dsp_grant_nxt;
  logic                     w_cpu_grant_nxt;
  logic                     w_last_cpu_nxt;
  logic [TIMEOUT_WIDTH-1:0] w_hold_nxt;
  logic [GUARD_WIDTH-1:0]   w_guard_nxt;
  logic                     w_timeout_nxt;
  logic                     w_revoke;
  logic                     w_dsp_req_s;
  logic                     w_cpu_req_s;
  logic                     w_owner_cs_s;

  // Two-flop synchronizers; bit 1 is the synchronized copy
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_dsp_req_sync <= 2'b00;
      r_cpu_req_sync <= 2'b00;
      r_dsp_cs_sync  <= 2'b11;
      r_cpu_cs_sync  <= 2'b11;
    end else begin
      r_dsp_req_sync <= {r_dsp_req_sync[0], dsp_req};
      r_cpu_req_sync <= {r_cpu_req_sync[0], cpu_req};
      r_dsp_cs_sync  <= {r_dsp_cs_sync[0], dsp_spi_cs_INV};
      r_cpu_cs_sync  <= {r_cpu_cs_sync[0], cpu_spi_cs_INV};
    end
  end

  assign w_dsp_req_s  = r_dsp_req_sync[1];
  assign w_cpu_req_s  = r_cpu_req_sync[1];
  assign w_owner_cs_s = r_dsp_grant ? r_dsp_cs_sync[1] : r_cpu_cs_sync[1];

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      r_state     <= S_IDLE;
      r_dsp_grant <= 1'b0;
      r_cpu_grant <= 1'b0;
      r_last_cpu  <= 1'b1;
      r_hold      <= '0;
      r_guard     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dsp_grant <= w_dsp_grant_nxt;
      r_cpu_grant <= w_cpu_grant_nxt;
      r_last_cpu  <= w_last_cpu_nxt;
      r_hold      <= w_hold_nxt;
      r_guard     <= w_guard_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_dsp_grant_nxt = r_dsp_grant;
    w_cpu_grant_nxt = r_cpu_grant;
    w_last_cpu_nxt  = r_last_cpu;
    w_hold_nxt      = r_hold;
    w_guard_nxt     = r_guard;
    w_timeout_nxt   = r_timeout;
    w_revoke        = 1'b0;

    if (!enable) begin
      w_state_nxt     = S_IDLE;
      w_dsp_grant_nxt = 1'b0;
      w_cpu_grant_nxt = 1'b0;
      w_hold_nxt      = '0;
      w_guard_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // On a tie the master that did not own last goes first
          if (w_dsp_req_s && (!w_cpu_req_s || r_last_cpu)) begin
            w_state_nxt     = S_OWN_DSP;
            w_dsp_grant_nxt = 1'b1;
            w_last_cpu_nxt  = 1'b0;
            w_hold_nxt      = '0;
          end else if (w_cpu_req_s) begin
            w_state_nxt     = S_OWN_CPU;
            w_cpu_grant_nxt = 1'b1;
            w_last_cpu_nxt  = 1'b1;
            w_hold_nxt      = '0;
          end
        end
        S_OWN_DSP, S_OWN_CPU: begin
          if (r_hold == HOLD_LAST) begin
            w_revoke = 1'b1;
          end else begin
            w_hold_nxt = r_hold + TIMEOUT_WIDTH'(1);
            if ((r_state == S_OWN_DSP) ? !w_dsp_req_s : !w_cpu_req_s) begin
              w_state_nxt = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_hold == HOLD_LAST) begin
            w_revoke = 1'b1;
          end else if (w_owner_cs_s) begin
            w_state_nxt     = S_GUARD;
            w_dsp_grant_nxt = 1'b0;
            w_cpu_grant_nxt = 1'b0;
            w_guard_nxt     = '0;
          end else begin
            w_hold_nxt = r_hold + TIMEOUT_WIDTH'(1);
          end
        end
        S_GUARD: begin
          if (r_guard == GUARD_LAST) begin
            w_state_nxt = S_IDLE;
            w_guard_nxt = '0;
          end else begin
            w_guard_nxt = r_guard + GUARD_WIDTH'(1);
          end
        end
        default: begin
          w_state_nxt     = S_IDLE;
          w_dsp_grant_nxt = 1'b0;
          w_cpu_grant_nxt = 1'b0;
        end
      endcase
    end

    // Watchdog revocation; a same-cycle clear loses to the set
    if (w_revoke) begin
      w_state_nxt     = S_GUARD;
      w_dsp_grant_nxt = 1'b0;
      w_cpu_grant_nxt = 1'b0;
      w_guard_nxt     = '0;
      w_timeout_nxt   = 1'b1;
    end else if (timeout_clr) begin
      w_timeout_nxt = 1'b0;
    end
  end

  assign dsp_grant = r_dsp_grant;
  assign cpu_grant = r_cpu_grant;
  assign timeout   = r_timeout;

  // Combinational SPI path steered by the grant registers
  assign flash_clk    = (r_dsp_grant & dsp_spi_clk)  | (r_cpu_grant & cpu_spi_clk);
  assign flash_mosi   = (r_dsp_grant & dsp_spi_mosi) | (r_cpu_grant & cpu_spi_mosi);
  assign flash_cs_INV = r_dsp_grant ? dsp_spi_cs_INV : (r_cpu_grant ? cpu_spi_cs_INV : 1'b1);
  assign dsp_spi_miso = r_dsp_grant & flash_miso;
  assign cpu_spi_miso = r_cpu_grant & flash_miso;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: datapath vector table, grant-event scoreboard with exact
// cycle timing, and hand sequences for tie, drain, watchdog and enable drop.
module tb_spi_flash_arbiter;

  localparam int unsigned GUARD   = 4;
  localparam int unsigned TIMEOUT = 100;

  logic sysclk = 1'b0;
  logic reset_INV, enable, dsp_req, cpu_req;
  logic dsp_spi_clk, dsp_spi_mosi, dsp_spi_cs_INV;
  logic cpu_spi_clk, cpu_spi_mosi, cpu_spi_cs_INV;
  logic flash_miso, timeout_clr;
  logic dsp_grant, cpu_grant, dsp_spi_miso, cpu_spi_miso;
  logic flash_clk, flash_mosi, flash_cs_INV, timeout;

  spi_flash_arbiter #(
    .GUARD_CYCLES  (GUARD),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .sysclk        (sysclk),
    .reset_INV     (reset_INV),
    .enable        (enable),
    .dsp_req       (dsp_req),
    .cpu_req       (cpu_req),
    .dsp_grant     (dsp_grant),
    .cpu_grant     (cpu_grant),
    .dsp_spi_clk   (dsp_spi_clk),
    .dsp_spi_mosi  (dsp_spi_mosi),
    .dsp_spi_cs_INV(dsp_spi_cs_INV),
    .dsp_spi_miso  (dsp_spi_miso),
    .cpu_spi_clk   (cpu_spi_clk),
    .cpu_spi_mosi  (cpu_spi_mosi),
    .cpu_spi_cs_INV(cpu_spi_cs_INV),
    .cpu_spi_miso  (cpu_spi_miso),
    .flash_clk     (flash_clk),
    .flash_mosi    (flash_mosi),
    .flash_cs_INV  (flash_cs_INV),
    .flash_miso    (flash_miso),
    .timeout       (timeout),
    .timeout_clr   (timeout_clr)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    string tag;
    int    cyc;
    logic  dsp;
    logic  cpu;
  } gev_t;

  typedef struct {
    logic [1:0] owner;
    logic       dclk, dmosi, dcs, cclk, cmosi, ccs, fmiso;
    logic [4:0] exp;  // {flash_clk, flash_mosi, flash_cs_INV, dsp_spi_miso, cpu_spi_miso}
  } dp_vec_t;

  gev_t    exp_q[$];
  gev_t    mon_ev;
  dp_vec_t vecs[8];
  int      cyc = 0;
  int      n_checks = 0;
  int      n_fail = 0;
  logic [1:0] prev_g = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input string tag, input int c, input logic d, input logic cp);
    gev_t e;
    e.tag = tag; e.cyc = c; e.dsp = d; e.cpu = cp;
    exp_q.push_back(e);
  endtask

  // Aligns to the falling edge that follows rising edge number t
  task automatic to_cycle(input int t);
    @(negedge sysclk);
    while (cyc < t) @(negedge sysclk);
  endtask

  task automatic idle_pins();
    dsp_spi_clk = 0; dsp_spi_mosi = 0; dsp_spi_cs_INV = 1;
    cpu_spi_clk = 0; cpu_spi_mosi = 0; cpu_spi_cs_INV = 1;
    flash_miso  = 0;
  endtask

  function automatic logic [31:0] idle_vec();
    return {24'd0, flash_cs_INV, flash_clk, flash_mosi, dsp_grant, cpu_grant,
            timeout, dsp_spi_miso, cpu_spi_miso};
  endfunction

  task automatic apply_vec(input logic [1:0] owner);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].owner == owner) begin
        dsp_spi_clk = vecs[i].dclk; dsp_spi_mosi = vecs[i].dmosi; dsp_spi_cs_INV = vecs[i].dcs;
        cpu_spi_clk = vecs[i].cclk; cpu_spi_mosi = vecs[i].cmosi; cpu_spi_cs_INV = vecs[i].ccs;
        flash_miso  = vecs[i].fmiso;
        #1;
        chk($sformatf("dp_vec%0d", i),
            {27'd0, flash_clk, flash_mosi, flash_cs_INV, dsp_spi_miso, cpu_spi_miso},
            {27'd0, vecs[i].exp});
      end
    end
  endtask

  // DSP sends 0x9F then clocks in a 24-bit JEDEC ID from the flash
  task automatic dsp_xfer();
    logic [31:0] tx, rsp, got_mosi, got_miso;
    logic cpu_seen;
    tx = 32'h9F00_0000; rsp = 32'h00EF_4018;
    got_mosi = '0; got_miso = '0; cpu_seen = 1'b0;
    dsp_spi_cs_INV = 0;
    for (int i = 31; i >= 0; i--) begin
      dsp_spi_mosi = tx[i];
      cpu_spi_mosi = ~tx[i];
      flash_miso   = rsp[i];
      #1;
      dsp_spi_clk = 1;
      #1;
      if (flash_clk) begin
        got_mosi = {got_mosi[30:0], flash_mosi};
        got_miso = {got_miso[30:0], dsp_spi_miso};
      end
      cpu_seen = cpu_seen | cpu_spi_miso;
      #1;
      dsp_spi_clk = 0;
      #1;
    end
    chk("xfer_cmd_0x9F", {24'd0, got_mosi[31:24]}, 32'h0000_009F);
    chk("xfer_jedec_id", {8'd0, got_miso[23:0]}, 32'h00EF_4018);
    chk("xfer_cpu_miso_quiet", {31'd0, cpu_seen}, 32'd0);
  endtask

  // Grant monitor: every change must match the next scoreboard entry at its exact cycle
  initial begin
    forever begin
      @(posedge sysclk);
      cyc = cyc + 1;
      #1;
      if ({dsp_grant, cpu_grant} != prev_g) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {30'd0, dsp_grant, cpu_grant}, {30'd0, prev_g});
        end else begin
          mon_ev = exp_q.pop_front();
          chk({mon_ev.tag, "_cycle"}, cyc, mon_ev.cyc);
          chk({mon_ev.tag, "_grant"}, {30'd0, dsp_grant, cpu_grant},
              {30'd0, mon_ev.dsp, mon_ev.cpu});
        end
        prev_g = {dsp_grant, cpu_grant};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int t, g, k;
    vecs[0] = '{2'd0, 1, 1, 0, 1, 1, 0, 1, 5'b00100};
    vecs[1] = '{2'd0, 0, 1, 1, 1, 0, 0, 1, 5'b00100};
    vecs[2] = '{2'd1, 1, 0, 0, 0, 1, 1, 1, 5'b10010};
    vecs[3] = '{2'd1, 0, 1, 1, 1, 0, 0, 0, 5'b01100};
    vecs[4] = '{2'd1, 1, 1, 0, 1, 1, 1, 1, 5'b11010};
    vecs[5] = '{2'd2, 1, 1, 0, 0, 1, 1, 1, 5'b01101};
    vecs[6] = '{2'd2, 0, 0, 1, 1, 0, 0, 0, 5'b10000};
    vecs[7] = '{2'd2, 1, 0, 1, 1, 1, 0, 1, 5'b11001};

    reset_INV = 0; enable = 1; dsp_req = 0; cpu_req = 0; timeout_clr = 0;
    idle_pins();

    // Reset with random inputs
    repeat (6) begin
      @(negedge sysclk);
      dsp_req = 1'($urandom); cpu_req = 1'($urandom);
      dsp_spi_clk = 1'($urandom); dsp_spi_mosi = 1'($urandom); dsp_spi_cs_INV = 1'($urandom);
      cpu_spi_clk = 1'($urandom); cpu_spi_mosi = 1'($urandom); cpu_spi_cs_INV = 1'($urandom);
      flash_miso = 1'($urandom); timeout_clr = 1'($urandom);
      #1;
      chk("reset_idle", idle_vec(), 32'h80);
    end
    @(negedge sysclk);
    dsp_req = 0; cpu_req = 0; timeout_clr = 0;
    idle_pins();
    reset_INV = 1;
    t = cyc;
    to_cycle(t + 4);
    chk("post_reset_idle", idle_vec(), 32'h80);
    apply_vec(2'd0);
    idle_pins();

    // Tie after reset: DSP wins
    to_cycle(cyc + 1);
    t = cyc;
    dsp_req = 1; cpu_req = 1;
    push("tie_dsp", t + 3, 1, 0);
    to_cycle(t + 3);
    apply_vec(2'd1);
    idle_pins();
    dsp_xfer();

    // DSP releases with cs high; CPU follows after the guard gap
    to_cycle(cyc + 1);
    dsp_spi_cs_INV = 1;
    to_cycle(cyc + 3);
    t = cyc;
    dsp_req = 0;
    push("dsp_release", t + 4, 0, 0);
    push("rr_cpu", t + 4 + GUARD + 1, 0, 1);
    to_cycle(t + 4 + GUARD + 1);
    apply_vec(2'd2);
    idle_pins();
    cpu_spi_cs_INV = 0;
    dsp_req = 1;

    // CPU drops request mid-transfer; grant held until cs is seen high
    to_cycle(cyc + 3);
    t = cyc;
    cpu_req = 0;
    to_cycle(t + 3 + 50);
    chk("drain_hold", {30'd0, dsp_grant, cpu_grant}, 32'b01);
    t = cyc;
    cpu_spi_cs_INV = 1;
    cpu_req = 1;
    push("drain_release", t + 3, 0, 0);
    push("rr_dsp", t + 3 + GUARD + 1, 1, 0);
    to_cycle(t + 2);
    chk("drain_hold_cs_sync", {30'd0, dsp_grant, cpu_grant}, 32'b01);
    to_cycle(t + 3 + GUARD + 1);

    // Watchdog: DSP keeps cs low past TIMEOUT cycles
    g = cyc;
    dsp_spi_cs_INV = 0;
    push("wd_revoke", g + TIMEOUT, 0, 0);
    push("wd_cpu", g + TIMEOUT + GUARD + 1, 0, 1);
    to_cycle(g + TIMEOUT - 1);
    chk("wd_pre_cs", {30'd0, flash_cs_INV, timeout}, 32'b00);
    to_cycle(g + TIMEOUT);
    chk("wd_cs_released", {31'd0, flash_cs_INV}, 32'd1);
    chk("wd_timeout_set", {31'd0, timeout}, 32'd1);
    to_cycle(g + TIMEOUT + GUARD + 2);

    // Enable drop while CPU owns with cs low
    t = cyc;
    dsp_spi_cs_INV = 1;
    cpu_spi_cs_INV = 0;
    enable = 0;
    dsp_req = 0;
    push("en_drop", t + 1, 0, 0);
    to_cycle(t + 1);
    chk("en_drop_cs", {31'd0, flash_cs_INV}, 32'd1);
    chk("en_timeout_kept", {31'd0, timeout}, 32'd1);
    to_cycle(t + 3);
    k = cyc;
    enable = 1;
    push("en_regrant", k + 1, 0, 1);
    to_cycle(k + 1);
    timeout_clr = 1;
    to_cycle(k + 2);
    timeout_clr = 0;
    chk("timeout_cleared", {31'd0, timeout}, 32'd0);

    // Final CPU release
    cpu_spi_cs_INV = 1;
    to_cycle(k + 5);
    t = cyc;
    cpu_req = 0;
    push("end_release", t + 4, 0, 0);
    to_cycle(t + 10);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
